// File: rtl/unary_matmul_scheduler_pkg.sv
// Shared definitions for the unary matmul job scheduler.
// Contents: the scheduler FSM state type, the requester-ID width helper
// and the default watchdog limit.
package unary_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } sched_state_e;

  // Default number of RUN cycles before a job is ended with an error.
  localparam int unsigned SCHED_TIMEOUT = 1024;

  // The ID is at least one bit wide, so a single requester still has a legal field.
  function automatic int unsigned sched_id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/unary_matmul_scheduler_if.sv
// Requester and response channels of the unary matmul scheduler.
// master: requesters and result consumer. They drive req_valid, req_A, req_B
//         and resp_ready.
// slave:  the scheduler. It drives req_ready, resp_valid, resp_id, resp_C
//         and resp_err.
interface unary_matmul_scheduler_if
  import unary_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BIT_WIDTH = 5,
  parameter int unsigned A_ROW     = 2,
  parameter int unsigned A_COL     = 2,
  parameter int unsigned B_COL     = 2
);

  localparam int unsigned ID_W = sched_id_w(NUM_REQ);
  localparam int unsigned C_W  = (BIT_WIDTH << 1) + A_COL;

  logic [NUM_REQ-1:0]                                  req_valid;
  logic [NUM_REQ-1:0]                                  req_ready;
  logic [NUM_REQ-1:0][A_ROW-1:0][A_COL-1:0][BIT_WIDTH-1:0] req_A;
  logic [NUM_REQ-1:0][A_COL-1:0][B_COL-1:0][BIT_WIDTH-1:0] req_B;

  logic                                  resp_valid;
  logic                                  resp_ready;
  logic [ID_W-1:0]                       resp_id;
  logic [A_ROW-1:0][B_COL-1:0][C_W-1:0]  resp_C;
  logic                                  resp_err;

  modport master (
    output req_valid, req_A, req_B, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_C, resp_err
  );

  modport slave (
    input  req_valid, req_A, req_B, resp_ready,
    output req_ready, resp_valid, resp_id, resp_C, resp_err
  );

endinterface

// File: rtl/unary_matmul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (request vector), rr_ptr (highest-priority index),
//        grant (one-hot), grant_idx (encoded grant). The grant is zero when
//        no request is set.
module rr_arbiter
  import unary_sched_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = sched_id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx
);

  int   idx;
  logic found;

  // Scan from rr_ptr upward with wrap-around and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < int'(N); k++) begin
      idx = (int'(rr_ptr) + k) % int'(N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/unary_matmul_scheduler.sv
// Shares one systolic_unary_matmul engine between NUM_REQ requesters.
// Ports: clk, reset_n (async, active-low); bus (requester/response channels);
//        eng_* (engine control, operands, completion flag and result);
//        busy (FSM not idle).
// Jobs are granted round-robin. The operands are latched and the engine is
// pulsed through reset for one cycle and then run. The result, or a timeout
// error, is returned with the owner's ID.
module unary_matmul_scheduler
  import unary_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BIT_WIDTH = 5,
  parameter int unsigned A_ROW     = 2,
  parameter int unsigned A_COL     = 2,
  parameter int unsigned B_COL     = 2,
  parameter int unsigned TIMEOUT   = SCHED_TIMEOUT
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  unary_matmul_scheduler_if.slave                     bus,
  output logic                                        eng_reset_n,
  output logic                                        eng_input_valid,
  output logic [A_ROW-1:0][A_COL-1:0][BIT_WIDTH-1:0]  eng_A,
  output logic [A_COL-1:0][B_COL-1:0][BIT_WIDTH-1:0]  eng_B,
  input  logic                                        eng_output_ready,
  input  logic [A_ROW-1:0][B_COL-1:0][(BIT_WIDTH<<1)+A_COL-1:0] eng_C,
  output logic                                        busy
);

  localparam int unsigned ID_W  = sched_id_w(NUM_REQ);
  localparam int unsigned C_W   = (BIT_WIDTH << 1) + A_COL;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  sched_state_e                               state_q;
  logic [ID_W-1:0]                            rr_ptr_q;
  logic [ID_W-1:0]                            cur_id_q;
  logic [A_ROW-1:0][A_COL-1:0][BIT_WIDTH-1:0] op_a_q;
  logic [A_COL-1:0][B_COL-1:0][BIT_WIDTH-1:0] op_b_q;
  logic [CNT_W-1:0]                           cnt_q;
  logic                                       eng_rst_q;
  logic                                       eng_iv_q;
  logic                                       resp_valid_q;
  logic [A_ROW-1:0][B_COL-1:0][C_W-1:0]       resp_c_q;
  logic                                       resp_err_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               timeout_hit;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cur_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      cnt_q        <= '0;
      eng_rst_q    <= 1'b0;
      eng_iv_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_c_q     <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.req_valid) begin
            op_a_q   <= bus.req_A[grant_idx];
            op_b_q   <= bus.req_B[grant_idx];
            cur_id_q <= grant_idx;
            state_q  <= LOAD;
          end
        end
        // The engine sits in reset for this cycle with the new operands already on its inputs.
        LOAD: begin
          cnt_q     <= '0;
          eng_rst_q <= 1'b1;
          eng_iv_q  <= 1'b1;
          state_q   <= RUN;
        end
        RUN: begin
          if (eng_output_ready || timeout_hit) begin
            // Completion takes priority over a watchdog expiry in the same cycle.
            resp_c_q     <= eng_output_ready ? eng_C : '0;
            resp_err_q   <= !eng_output_ready;
            resp_valid_q <= 1'b1;
            eng_rst_q    <= 1'b0;
            eng_iv_q     <= 1'b0;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr_q     <= (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with reset_n means an async reset parks the engine without waiting for a clock.
  assign eng_reset_n     = eng_rst_q & reset_n;
  assign eng_input_valid = eng_iv_q;
  assign eng_A           = op_a_q;
  assign eng_B           = op_b_q;
  assign busy            = (state_q != IDLE);

  assign bus.req_ready  = (state_q == IDLE) ? grant : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = cur_id_q;
  assign bus.resp_C     = resp_c_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_unary_matmul_scheduler.sv
// Bench for unary_matmul_scheduler: behavioural engine model, directed jobs,
// and a scoreboard queue drained by an independent response monitor.
module tb_unary_matmul_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned BW      = 5;
  localparam int unsigned C_W     = 12;
  localparam int          ENG_LAT = 108;

  typedef logic [1:0][1:0][BW-1:0]  op_mat_t;
  typedef logic [1:0][1:0][C_W-1:0] c_mat_t;

  typedef struct {
    logic [1:0] id;
    c_mat_t     c;
    logic       err;
    int         lat_min;
    int         lat_max;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic eng_reset_n, eng_input_valid, eng_output_ready, busy;
  op_mat_t eng_A, eng_B;
  c_mat_t  eng_C;
  logic    eng_stuck;

  unary_matmul_scheduler_if #(
    .NUM_REQ(NUM_REQ), .BIT_WIDTH(BW), .A_ROW(2), .A_COL(2), .B_COL(2)
  ) bus ();

  unary_matmul_scheduler #(
    .NUM_REQ(NUM_REQ), .BIT_WIDTH(BW), .A_ROW(2), .A_COL(2), .B_COL(2), .TIMEOUT(1024)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .eng_reset_n      (eng_reset_n),
    .eng_input_valid  (eng_input_valid),
    .eng_A            (eng_A),
    .eng_B            (eng_B),
    .eng_output_ready (eng_output_ready),
    .eng_C            (eng_C),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: ready after ENG_LAT valid cycles following its reset.
  int ecnt;
  always @(posedge clk or negedge eng_reset_n) begin
    if (!eng_reset_n) ecnt <= 0;
    else if (eng_input_valid && ecnt < ENG_LAT) ecnt <= ecnt + 1;
  end
  assign eng_output_ready = !eng_stuck && eng_reset_n && (ecnt == ENG_LAT);

  always_comb begin
    int acc;
    eng_C = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int k = 0; k < 2; k++)
          acc += int'($signed(eng_A[i][k])) * int'($signed(eng_B[k][j]));
        eng_C[i][j] = C_W'(acc);
      end
    end
  end

  function automatic op_mat_t mk_op(input int x00, input int x01, input int x10, input int x11);
    op_mat_t m;
    m[0][0] = BW'(x00); m[0][1] = BW'(x01); m[1][0] = BW'(x10); m[1][1] = BW'(x11);
    return m;
  endfunction

  function automatic c_mat_t mk_c(input int x00, input int x01, input int x10, input int x11);
    c_mat_t m;
    m[0][0] = C_W'(x00); m[0][1] = C_W'(x01); m[1][0] = C_W'(x10); m[1][1] = C_W'(x11);
    return m;
  endfunction

  c_mat_t exp_c [NUM_REQ];
  exp_t   sb_q[$];
  int     accept_cyc [NUM_REQ];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: latency on the first RESP cycle, contents on the handshake.
  logic in_resp = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_resp = 1'b0;
    end else if (bus.resp_valid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_resp: got id %0d, required no response", bus.resp_id);
        end else if ((cyc - accept_cyc[sb_q[0].id]) >= sb_q[0].lat_min &&
                     (cyc - accept_cyc[sb_q[0].id]) <= sb_q[0].lat_max) begin
          n_pass++;
        end else begin
          $display("FAIL latency id%0d: got %0d cycles, required %0d..%0d", sb_q[0].id,
                   cyc - accept_cyc[sb_q[0].id], sb_q[0].lat_min, sb_q[0].lat_max);
        end
      end
      if (bus.resp_ready) begin
        in_resp = 1'b0;
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("resp_id", 64'(bus.resp_id), 64'(e.id));
          chk("resp_C", 64'(bus.resp_C), 64'(e.c));
          chk("resp_err", 64'(bus.resp_err), 64'(e.err));
        end
      end
    end
  end

  // One clock; requests accepted at this edge are withdrawn afterwards.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    for (int i = 0; i < int'(NUM_REQ); i++) if (acc[i]) accept_cyc[i] = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic push_job(input int id, input logic err, input int lmin, input int lmax);
    exp_t e;
    e.id = 2'(id); e.c = err ? '0 : exp_c[id]; e.err = err; e.lat_min = lmin; e.lat_max = lmax;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((bus.req_valid != '0 || busy || sb_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(n < budget), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_eng_reset_n"}, 64'(eng_reset_n), 64'd0);
    chk({tag, "_eng_input_valid"}, 64'(eng_input_valid), 64'd0);
    chk({tag, "_eng_A"}, 64'(eng_A), 64'd0);
    chk({tag, "_eng_B"}, 64'(eng_B), 64'd0);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_resp_id"}, 64'(bus.resp_id), 64'd0);
    chk({tag, "_resp_C"}, 64'(bus.resp_C), 64'd0);
    chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_reset_vals(tag);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    c_mat_t held_c;
    int     n;
    reset_n        = 1'b0;
    eng_stuck      = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    bus.req_A[0] = mk_op(1, 2, 3, 4);      bus.req_B[0] = mk_op(5, 6, 7, -8);
    bus.req_A[1] = mk_op(-1, 0, 2, -3);    bus.req_B[1] = mk_op(4, 1, -2, 5);
    bus.req_A[2] = mk_op(15, -16, 0, 1);   bus.req_B[2] = mk_op(15, 15, -16, -16);
    bus.req_A[3] = mk_op(7, 7, 7, 7);      bus.req_B[3] = mk_op(1, 0, 0, 1);
    exp_c[0] = mk_c(19, -10, 43, -14);
    exp_c[1] = mk_c(-4, -1, 14, -13);
    exp_c[2] = mk_c(481, 481, -16, -16);
    exp_c[3] = mk_c(7, 7, 7, 7);
    for (int i = 0; i < int'(NUM_REQ); i++) accept_cyc[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("post_rst");

    // Single job from requester 0.
    push_job(0, 1'b0, 1, 112);
    bus.req_valid[0] = 1'b1;
    wait_drain("single_drain", 300);

    // Fresh reset, then two rounds with all four requesting.
    pulse_reset("rst2");
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) push_job(i, 1'b0, 1, 112);
      bus.req_valid = '1;
      wait_drain("round_drain", 600);
    end

    // Consumer stalls for 50 cycles while requester 1 waits.
    bus.resp_ready = 1'b0;
    push_job(0, 1'b0, 1, 112);
    push_job(1, 1'b0, 1, 112);
    bus.req_valid[0] = 1'b1;
    n = 0;
    while (!bus.resp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("stall_reach_resp", 64'(bus.resp_valid), 64'd1);
    bus.req_valid[1] = 1'b1;
    held_c = bus.resp_C;
    chk("stall_held_c", 64'(held_c), 64'(exp_c[0]));
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("stall_valid", 64'(bus.resp_valid), 64'd1);
      chk("stall_c", 64'(bus.resp_C), 64'(held_c));
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_eng_iv", 64'(eng_input_valid), 64'd0);
    end
    bus.resp_ready = 1'b1;
    wait_drain("stall_drain", 400);

    // rr_ptr is now 2; serving 2 moves it to 3, then 2 alone must wrap.
    push_job(2, 1'b0, 1, 112);
    bus.req_valid[2] = 1'b1;
    wait_drain("req2_drain", 300);
    push_job(2, 1'b0, 1, 112);
    bus.req_valid[2] = 1'b1;
    #1;
    chk("wrap_grant", 64'(bus.req_ready), 64'b0100);
    wait_drain("wrap_drain", 300);

    // Engine never completes: error after exactly TIMEOUT RUN cycles.
    eng_stuck = 1'b1;
    push_job(3, 1'b1, 1026, 1026);
    bus.req_valid[3] = 1'b1;
    wait_drain("timeout_drain", 1300);
    eng_stuck = 1'b0;
    chk("timeout_idle", 64'(busy), 64'd0);

    // Reset mid-RUN aborts the job silently; the next one completes.
    bus.req_valid[0] = 1'b1;
    repeat (20) tick();
    chk("midrun_busy", 64'(busy), 64'd1);
    chk("midrun_eng_iv", 64'(eng_input_valid), 64'd1);
    pulse_reset("midrun_rst");
    push_job(1, 1'b0, 1, 112);
    bus.req_valid[1] = 1'b1;
    wait_drain("after_rst_drain", 300);
    repeat (5) tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/unary_matmul_scheduler.md
# unary_matmul_scheduler

Job scheduler in front of one `systolic_unary_matmul` engine. It shares the engine between `NUM_REQ` requesters using round-robin arbitration, latches the granted operands, and restarts the engine for each job. It then waits for the engine's `output_ready`, captures `C`, and returns the result with the requester ID over a valid/ready response channel. A watchdog ends any job whose engine never reports ready.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥1).
- `BIT_WIDTH`, 5: operand width, must match engine.
- `A_ROW`, 2; `A_COL`, 2; `B_COL`, 2: engine dimensions; `B_ROW` = `A_COL`.
- `TIMEOUT`, 1024: maximum RUN cycles before error completion.
- Derived: `ID_W` = max(1, $clog2(NUM_REQ)); `C_W` = (BIT_WIDTH<<1)+A_COL.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, NUM_REQ: per-requester job request.
- `req_ready`, out, NUM_REQ: one-hot accept for the current cycle.
- `req_A`, in, NUM_REQ×A_ROW×A_COL×BIT_WIDTH: operand A per requester.
- `req_B`, in, NUM_REQ×A_COL×B_COL×BIT_WIDTH: operand B per requester.
- `eng_reset_n`, out, 1: engine reset/restart, active-low.
- `eng_input_valid`, out, 1: drives engine `input_valid`.
- `eng_A`, out, A_ROW×A_COL×BIT_WIDTH: engine A operand.
- `eng_B`, out, A_COL×B_COL×BIT_WIDTH: engine B operand.
- `eng_output_ready`, in, 1: engine completion flag.
- `eng_C`, in, A_ROW×B_COL×C_W: engine result.
- `resp_valid`, out, 1: result available.
- `resp_ready`, in, 1: consumer accepts result.
- `resp_id`, out, ID_W: requester that owns the result.
- `resp_C`, out, A_ROW×B_COL×C_W: captured result.
- `resp_err`, out, 1: job ended by timeout.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any `req_valid` is set, the round-robin arbiter picks the first set bit at or after `rr_ptr`, wrapping.
  - `req_ready[g]` goes high combinationally in the same cycle.
  - At the clock edge: latch `req_A[g]`/`req_B[g]` into operand registers, set `cur_id`=g, go to LOAD.
  - If no request is valid, stay in IDLE.
- LOAD: one cycle.
  - `eng_reset_n`=0 clears the engine's counters and pipelines.
  - The operand registers already drive `eng_A`/`eng_B`.
  - Clear the cycle counter, then go to RUN.
- RUN:
  - `eng_reset_n`=1, `eng_input_valid`=1; the cycle counter increments each cycle.
  - The first cycle `eng_output_ready`=1: capture `eng_C` into `resp_C`, set `resp_err`=0, go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT`-1: set `resp_C`=0 and `resp_err`=1, go to RESP.
  - If both conditions hold in the same cycle, `output_ready` wins.
- RESP:
  - `resp_valid`=1 with stable `resp_id`, `resp_C` and `resp_err` until `resp_ready`=1.
  - On the accepting edge: set `rr_ptr` = (`cur_id`+1) mod NUM_REQ, go to IDLE.
- Operand registers hold from LOAD through RESP. The engine samples A/B every cycle, so the operands must stay stable for the whole job.
- `req_ready` is 0 outside IDLE. Requests are never dropped: a requester keeps `req_valid` high until it sees `req_ready`.
- Result arithmetic is the engine's; the scheduler passes `C_W`-bit values through without modification.

## Timing
- Reset values:
  - `req_ready`=0, `eng_reset_n`=0, `eng_input_valid`=0, `eng_A`/`eng_B`=0.
  - `resp_valid`=0, `resp_id`=0, `resp_C`=0, `resp_err`=0, `busy`=0.
  - `rr_ptr`=0, state IDLE.
- `eng_reset_n` is a registered value ANDed with `reset_n`, so the engine resets immediately on an async reset.
- In IDLE, `eng_reset_n` is held at 0 so the engine stays parked.
- Accept-to-LOAD latency is 1 cycle; LOAD lasts exactly 1 cycle.
- RUN length: the engine's (A_ROW+A_COL+B_ROW) data periods of ((1<<(BIT_WIDTH-1))+2) cycles each. For the defaults, 6×18 = 108 cycles, plus up to 1 cycle of sampling delay.
- Completion-to-`resp_valid` latency is 1 cycle.
- Back-to-back throughput: a new accept is possible in the cycle after the `resp_ready` handshake.
- `reset_n` asserted mid-job aborts the job with no response. The requester must re-issue it.

## Structure
- Package `unary_sched_pkg` holds:
  - the state enum (`IDLE`, `LOAD`, `RUN`, `RESP`);
  - a `sched_id_w(n)` function;
  - the `TIMEOUT` default constant.
- Sub-module `rr_arbiter #(N)`:
  - inputs: request vector and `rr_ptr`;
  - outputs: one-hot grant and encoded index;
  - purely combinational.

## Test plan
- Single job from requester 0 (BIT_WIDTH 5): A=[[1,2],[3,4]], B=[[5,6],[7,-8]] -> one `resp_valid` with `resp_id`=0, `resp_C`=[[19,-10],[43,-14]], `resp_err`=0, within 112 cycles of accept.
- All four requesters valid simultaneously after reset -> grants in order 0,1,2,3, each result correct and tagged with its own ID. A second round restarts at 0.
- `resp_ready` held low for 50 cycles in RESP -> `resp_valid` and `resp_C` stay stable, no new `req_ready`, `eng_input_valid` stays 0.
- Engine model never asserts `output_ready` -> `resp_err`=1 and `resp_C`=0 after exactly `TIMEOUT` RUN cycles; the scheduler then returns to IDLE.
- `reset_n` pulsed low mid-RUN -> all outputs at reset values immediately, no response for the aborted job; the next request completes normally.
- Requester 2 valid only, `rr_ptr`=3 -> wrap-around grants requester 2 in the first IDLE cycle.
